fp_mult_dg_feeder: RTL and testbench

FP_MULT_DG_FEEDER -- requirements
Module: fp_mult_dg_feeder

---
 rtl/fp_mult_dg_feeder.sv | 99 +++++++++
 tb/tb_fp_mult_dg_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_dg_feeder.sv
// rtl/fp_mult_dg_feeder.sv - two-stage operand/result feeder for a data-gated FP multiplier
// Optional sticky exception register built when FP_MULT_FEEDER_STICKY_EN is defined.
module fp_mult_dg_feeder #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sig_width+exp_width:0]   in_a,
  input  logic [sig_width+exp_width:0]   in_b,
  input  logic [2:0]                     in_rnd,
  output logic [sig_width+exp_width:0]   mul_a,
  output logic [sig_width+exp_width:0]   mul_b,
  output logic [2:0]                     mul_rnd,
  output logic                           mul_dg_ctrl,
  input  logic [sig_width+exp_width:0]   mul_z,
  input  logic [7:0]                     mul_status,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [sig_width+exp_width:0]   out_z,
  output logic [7:0]                     out_status,
  input  logic                           sticky_clr,
  output logic [7:0]                     sticky_status
);
  localparam int W = sig_width + exp_width + 1;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [2:0]   s1_rnd;
  logic         s2_free;
  logic         advance;
  logic         accept;

  assign s2_free  = !out_valid || out_ready;
  assign advance  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;

  // Operand registers only load on accept so the gated multiplier inputs stay quiet when idle.
  assign mul_a       = s1_a;
  assign mul_b       = s1_b;
  assign mul_rnd     = s1_rnd;
  assign mul_dg_ctrl = s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_rnd   <= 3'd0;
    end else begin
      s1_valid <= accept || (s1_valid && !advance);
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_rnd <= in_rnd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_status <= 8'h00;
    end else if (advance) begin
      out_valid  <= 1'b1;
      out_z      <= mul_z;
      out_status <= mul_status;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef FP_MULT_FEEDER_STICKY_EN
  logic [7:0] sticky_q;

  // A clear coinciding with an advance keeps only the newly captured flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 8'h00;
    end else if (sticky_clr) begin
      sticky_q <= advance ? mul_status : 8'h00;
    end else if (advance) begin
      sticky_q <= sticky_q | mul_status;
    end
  end

  assign sticky_status = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_status     = 8'h00;
`endif

endmodule

// File: tb/tb_fp_mult_dg_feeder.sv
// tb/tb_fp_mult_dg_feeder.sv - directed bench for fp_mult_dg_feeder with a stand-in multiplier
// Expects sticky behaviour only when FP_MULT_FEEDER_STICKY_EN is defined.
module tb_fp_mult_dg_feeder;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_rnd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [2:0]  mul_rnd;
  logic        mul_dg_ctrl;
  logic [31:0] mul_z;
  logic [7:0]  mul_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        sticky_clr;
  logic [7:0]  sticky_status;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic        started = 1'b0;
  logic [39:0] exp_q[$];
  int          pop_cycle[$];

  fp_mult_dg_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd), .mul_dg_ctrl(mul_dg_ctrl),
    .mul_z(mul_z), .mul_status(mul_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
    .sticky_clr(sticky_clr), .sticky_status(sticky_status)
  );

  // Stand-in for the external multiplier: exact for the IEEE cases used, a fixed hash otherwise.
  function automatic logic [39:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] r);
    if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) ||
        (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0))
      return {8'h04, 32'h7FC00000};
    if (a == 32'h3FC00000 && b == 32'h40000000)
      return {8'h00, 32'h40400000};
    return {a[7:0] ^ b[15:8] ^ {5'b0, r}, a ^ {b[15:0], b[31:16]} ^ {29'b0, r}};
  endfunction

  logic [39:0] mul_resp;
  assign mul_resp   = mul_model(mul_a, mul_b, mul_rnd);
  assign mul_z      = mul_resp[31:0];
  assign mul_status = mul_resp[39:32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  logic        stall_prev = 1'b0;
  logic        have_prev  = 1'b0;
  logic [31:0] prev_z, prev_a, prev_b;
  logic [7:0]  prev_st;

  always @(negedge clk) begin
    if (!rst_n || !started) begin
      stall_prev = 1'b0;
      have_prev  = 1'b0;
    end else begin
      cyc++;
      check("in_ready_vs_occupancy", in_ready, (exp_q.size() < 2) || out_ready);
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_z_stable", out_z, prev_z);
        check("stall_status_stable", out_status, prev_st);
      end
      if (have_prev && !mul_dg_ctrl) begin
        check("idle_mul_a_hold", mul_a, prev_a);
        check("idle_mul_b_hold", mul_b, prev_b);
      end
`ifndef FP_MULT_FEEDER_STICKY_EN
      check("sticky_const_zero", sticky_status, 8'h00);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got z=%0h with no pending pair", out_z);
        end else begin
          check("result", {out_status, out_z}, exp_q.pop_front());
          pop_cycle.push_back(cyc);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(mul_model(in_a, in_b, in_rnd));
      stall_prev = out_valid && !out_ready;
      prev_z = out_z; prev_st = out_status;
      prev_a = mul_a; prev_b = mul_b;
      have_prev = 1'b1;
    end
  end

  // Caller is #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r,
                      output int waited);
    in_a = a; in_b = b; in_rnd = r; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles expected 1", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w;
  int n;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = '0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dg_ctrl", mul_dg_ctrl, 1'b0);
    check("rst_out_z", out_z, 32'h0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_sticky", sticky_status, 8'h00);
    tick(3);
    rst_n = 1'b1;
    started = 1'b1;
    check("ready_after_release", in_ready, 1'b1);

    // 1.5 * 2.0 with two-edge latency
    tick(1);
    send(32'h3FC00000, 32'h40000000, 3'd0, w);
    @(negedge clk);
    check("lat_valid_edge1", out_valid, 1'b0);
    check("lat_dg_edge1", mul_dg_ctrl, 1'b1);
    @(negedge clk);
    check("lat_valid_edge2", out_valid, 1'b1);
    check("lat_z", out_z, 32'h40400000);
    check("lat_status", out_status, 8'h00);

    // inf * 0 -> invalid
    tick(2);
    send(32'h7F800000, 32'h00000000, 3'd0, w);
    @(negedge clk);
    @(negedge clk);
    check("nan_z", out_z, 32'h7FC00000);
    check("nan_status_bit2", out_status[2], 1'b1);
    tick(3);
`ifdef FP_MULT_FEEDER_STICKY_EN
    check("sticky_nan_held", sticky_status[2], 1'b1);
`else
    check("sticky_nan_held", sticky_status[2], 1'b0);
`endif
    sticky_clr = 1'b1;
    tick(1);
    sticky_clr = 1'b0;
    check("sticky_cleared", sticky_status, 8'h00);

    // clear coincident with an advance keeps only the captured flags
    send(32'h12345678, 32'h0000AB00, 3'd0, w);
    send(32'h7F800000, 32'h00000000, 3'd0, w);
`ifdef FP_MULT_FEEDER_STICKY_EN
    check("sticky_accum", sticky_status, 8'hD3);
`else
    check("sticky_accum", sticky_status, 8'h00);
`endif
    sticky_clr = 1'b1;
    tick(1);
    sticky_clr = 1'b0;
`ifdef FP_MULT_FEEDER_STICKY_EN
    check("sticky_clr_and_adv", sticky_status, 8'h04);
`else
    check("sticky_clr_and_adv", sticky_status, 8'h00);
`endif
    tick(3);

    // eight back-to-back pairs
    n = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'h40000000 + i * 32'h00010203, 32'h3F800000 ^ (i << 9), 3'(i), w);
      n += w;
    end
    check("stream_no_stall", n, 0);
    tick(4);
    check("stream_consecutive", pop_cycle[$] - pop_cycle[$-7], 7);

    // backpressure: two accepted, third waits
    out_ready = 1'b0;
    send(32'hAAAA0001, 32'h5555000F, 3'd1, w);
    send(32'hAAAA0002, 32'h5555001F, 3'd2, w);
    in_a = 32'hAAAA0003; in_b = 32'h5555002F; in_rnd = 3'd3; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_ready_low", in_ready, 1'b0);
    check("bp_dg_ctrl", mul_dg_ctrl, 1'b1);
    check("bp_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_third_accepted", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tick(5);
    check("bp_drained", exp_q.size(), 0);

    // reset with both stages occupied
    out_ready = 1'b0;
    send(32'h01020304, 32'h0A0B0C0D, 3'd0, w);
    send(32'h11121314, 32'h1A1B1C1D, 3'd0, w);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_dg", mul_dg_ctrl, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_dg", mul_dg_ctrl, 1'b0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("ready_after_rerelease", in_ready, 1'b1);
    tick(5);
    check("no_stale_output", out_valid, 1'b0);
    send(32'h3FC00000, 32'h40000000, 3'd0, w);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_z", out_z, 32'h40400000);

    // idle: gated inputs must hold every cycle
    tick(11);
    check("idle_dg_ctrl", mul_dg_ctrl, 1'b0);
    check("idle_mul_a", mul_a, 32'h3FC00000);
    check("end_nothing_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
